// File: rtl/debounce_select.sv
// debounce_select: two bouncing push-buttons step a 2-bit demux select.
// Switch 1 steps the select up and switch 2 steps it down, both modulo 4.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_switch_1     raw "step up" button, high = pressed
//   i_switch_2     raw "step down" button, high = pressed
//   o_sel0/o_sel1  registered select bits {o_sel1, o_sel0} = sel
//   o_switch_1_db  debounced level of i_switch_1
//   o_switch_2_db  debounced level of i_switch_2
//   o_sel_changed  one-cycle pulse, coincident with a new select value

// ---------------------------------------------------------------------
// debounce_select_chan: one switch channel.
// It synchronises the raw input, debounces it and flags presses.
//
// Ports:
//   i_clk    system clock
//   i_rst    asynchronous active-high reset
//   i_raw    raw asynchronous switch input
//   o_level  debounced stable level
//   o_press  high for one cycle, the first cycle o_level is seen high
// ---------------------------------------------------------------------
module debounce_select_chan #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic          r_level_d;
    logic [CW-1:0] r_cnt;

    logic          w_differ;
    logic          w_accept;

    // Two-flop synchroniser; only r_sync feeds the debouncer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    assign w_differ = (r_sync != r_level);
    assign w_accept = w_differ && (r_cnt == LAST);

    // The counter counts consecutive cycles in which the synchronised
    // value disagrees with the stable level. Any agreement clears it,
    // so a short glitch restarts the count from zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (!w_differ) begin
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_level <= r_sync;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + ONE;
        end
    end

    // Delayed copy for rising-edge detection of the stable level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= r_level;
        end
    end

    assign o_level = r_level;
    assign o_press = r_level & ~r_level_d;

endmodule

// ---------------------------------------------------------------------
// debounce_select: top level.
// ---------------------------------------------------------------------
module debounce_select #(
    parameter int         DEBOUNCE_LIMIT = 250000,
    parameter logic [1:0] RESET_SEL      = 2'd0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_switch_1,
    input  logic i_switch_2,
    output logic o_sel0,
    output logic o_sel1,
    output logic o_switch_1_db,
    output logic o_switch_2_db,
    output logic o_sel_changed
);

    logic       w_level_1;
    logic       w_level_2;
    logic       w_press_1;
    logic       w_press_2;
    logic       w_step_up;
    logic       w_step_dn;

    logic [1:0] r_sel;
    logic       r_changed;

    debounce_select_chan #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_chan_1 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_raw   (i_switch_1),
        .o_level (w_level_1),
        .o_press (w_press_1)
    );

    debounce_select_chan #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_chan_2 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_raw   (i_switch_2),
        .o_level (w_level_2),
        .o_press (w_press_2)
    );

    // Simultaneous presses cancel each other out.
    assign w_step_up = w_press_1 & ~w_press_2;
    assign w_step_dn = w_press_2 & ~w_press_1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sel     <= RESET_SEL;
            r_changed <= 1'b0;
        end else begin
            r_changed <= w_step_up | w_step_dn;
            if (w_step_up) begin
                r_sel <= r_sel + 2'd1;
            end else if (w_step_dn) begin
                r_sel <= r_sel - 2'd1;
            end
        end
    end

    assign o_sel0        = r_sel[0];
    assign o_sel1        = r_sel[1];
    assign o_switch_1_db = w_level_1;
    assign o_switch_2_db = w_level_2;
    assign o_sel_changed = r_changed;

endmodule
